// File: rtl/sprite_pkg.sv
// Shared geometry, entity-word layout and helpers for the sprite compositor.
package sprite_pkg;

  localparam int NUM_ENTITIES_DEF   = 9;
  localparam int ID_W_DEF           = 4;
  localparam int LOC_W_DEF          = 8;
  localparam int TILE_PX_DEF        = 8;
  localparam int UPSCALE_DEF        = 5;
  localparam int SCREEN_TILES_H_DEF = 16;
  localparam int SCREEN_TILES_V_DEF = 12;

  localparam int ENTITY_W   = ID_W_DEF + 2 + LOC_W_DEF;
  localparam int LOC_LSB    = 0;
  localparam int ORIENT_LSB = LOC_W_DEF;
  localparam int ID_LSB     = LOC_W_DEF + 2;

  localparam logic [ID_W_DEF-1:0] UNUSED_ID = '1;
  localparam int TILE_LEN = TILE_PX_DEF * UPSCALE_DEF;

  localparam int CNT_W = 10;
  // Wide enough for row*16+col at the largest counter value (25*16+25).
  localparam int IDX_W = 11;
  localparam int PX_W  = $clog2(TILE_PX_DEF);

  function automatic logic [IDX_W-1:0] tile_index(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    col = CNT_W'(h / TILE_LEN);
    row = CNT_W'(v / TILE_LEN);
    return IDX_W'(row) * IDX_W'(SCREEN_TILES_H_DEF) + IDX_W'(col);
  endfunction

  function automatic logic [PX_W-1:0] flip_col(input logic [PX_W-1:0] col,
                                              input logic            flip);
    return flip ? (PX_W'(TILE_PX_DEF - 1) - col) : col;
  endfunction

endpackage

// File: rtl/sprite_hit_detector.sv
// Compares one shadowed entity against the stage-1 tile coordinate.
module sprite_hit_detector
  import sprite_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int LOC_W = LOC_W_DEF
) (
  input  logic [ID_W-1:0]  id_i,
  input  logic [LOC_W-1:0] loc_i,
  input  logic [IDX_W-1:0] tile_idx_i,
  input  logic             in_area_i,
  output logic             hit_o
);

  // Zero-extending the location keeps large tile indices from aliasing.
  assign hit_o = in_area_i && (id_i != {ID_W{1'b1}}) &&
                 (IDX_W'(loc_i) == tile_idx_i);

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: per-frame entity snapshot, priority hit,
// external ROM lookup, flip and colour. Optional SPRITE_COLLISION_EN adds
// sticky collision / collision_mask outputs.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_ENTITIES   = NUM_ENTITIES_DEF,
  parameter int ID_W           = ID_W_DEF,
  parameter int LOC_W          = LOC_W_DEF,
  parameter int TILE_PX        = TILE_PX_DEF,
  parameter int UPSCALE        = UPSCALE_DEF,
  parameter int SCREEN_TILES_H = SCREEN_TILES_H_DEF,
  parameter int SCREEN_TILES_V = SCREEN_TILES_V_DEF,
  parameter logic [NUM_ENTITIES-1:0] FLIP_MASK = 9'b110000000,
  parameter logic BG_COLOUR    = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_ENTITIES*(ID_W+2+LOC_W)-1:0]     entities,
  input  logic [9:0]                                 counter_H,
  input  logic [9:0]                                 counter_V,
  output logic [ID_W-1:0]                            rom_sprite_id,
  output logic [1:0]                                 rom_orient,
  output logic [$clog2(TILE_PX)-1:0]                 rom_line,
  input  logic [TILE_PX-1:0]                         rom_data,
  output logic                                       colour,
`ifdef SPRITE_COLLISION_EN
  output logic                                       collision,
  output logic [NUM_ENTITIES-1:0]                    collision_mask,
`endif
  output logic [$clog2(NUM_ENTITIES+1)-1:0]          hit_channel
);

  localparam int EW   = ID_W + 2 + LOC_W;
  localparam int LN_W = $clog2(TILE_PX);
  localparam int CH_W = $clog2(NUM_ENTITIES + 1);
  localparam int T_LEN = TILE_PX * UPSCALE;
  localparam logic [9:0] AREA_H = 10'(SCREEN_TILES_H * T_LEN);
  localparam logic [9:0] AREA_V = 10'(SCREEN_TILES_V * T_LEN);
  localparam logic [CH_W-1:0] NO_CH = CH_W'(NUM_ENTITIES);

  logic snap;
  assign snap = (counter_H == 10'd0) && (counter_V == 10'd0);

  // Shadow entity table, refreshed only on the (0,0) edge.
  logic [ID_W-1:0]  sh_id_q     [NUM_ENTITIES];
  logic [1:0]       sh_orient_q [NUM_ENTITIES];
  logic [LOC_W-1:0] sh_loc_q    [NUM_ENTITIES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NUM_ENTITIES; n++) sh_id_q[n] <= '1;
    end else if (snap) begin
      for (int n = 0; n < NUM_ENTITIES; n++)
        sh_id_q[n] <= entities[n*EW + ID_LSB +: ID_W];
    end
  end

  always_ff @(posedge clk) begin
    if (snap) begin
      for (int n = 0; n < NUM_ENTITIES; n++) begin
        sh_orient_q[n] <= entities[n*EW + ORIENT_LSB +: 2];
        sh_loc_q[n]    <= entities[n*EW + LOC_LSB +: LOC_W];
      end
    end
  end

  // ---- Stage 1: tile coordinates and in-sprite pixel offsets ----
  logic [IDX_W-1:0] s1_idx_d, s1_idx_q;
  logic             s1_in_d,  s1_in_q;
  logic [LN_W-1:0]  s1_pxc_d, s1_pxc_q;
  logic [LN_W-1:0]  s1_pxr_d, s1_pxr_q;

  always_comb begin
    s1_idx_d = tile_index(counter_H, counter_V);
    s1_in_d  = (counter_H < AREA_H) && (counter_V < AREA_V);
    s1_pxc_d = LN_W'((counter_H % T_LEN) / UPSCALE);
    s1_pxr_d = LN_W'((counter_V % T_LEN) / UPSCALE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_idx_q <= '0;
      s1_in_q  <= 1'b0;
      s1_pxc_q <= '0;
      s1_pxr_q <= '0;
    end else begin
      s1_idx_q <= s1_idx_d;
      s1_in_q  <= s1_in_d;
      s1_pxc_q <= s1_pxc_d;
      s1_pxr_q <= s1_pxr_d;
    end
  end

  logic [NUM_ENTITIES-1:0] hits;

  for (genvar g = 0; g < NUM_ENTITIES; g++) begin : g_det
    sprite_hit_detector #(
      .ID_W  (ID_W),
      .LOC_W (LOC_W)
    ) u_det (
      .id_i       (sh_id_q[g]),
      .loc_i      (sh_loc_q[g]),
      .tile_idx_i (s1_idx_q),
      .in_area_i  (s1_in_q),
      .hit_o      (hits[g])
    );
  end

  // ---- Stage 2: priority winner and ROM address ----
  logic [CH_W-1:0] win_d;
  logic [ID_W-1:0] win_id_d;
  logic [1:0]      win_or_d;
  logic            win_flip_d;
  logic            found;

  always_comb begin
    win_d      = NO_CH;
    win_id_d   = '1;
    win_or_d   = 2'd0;
    win_flip_d = 1'b0;
    found      = 1'b0;
    for (int n = 0; n < NUM_ENTITIES; n++) begin
      if (!found && hits[n]) begin
        found      = 1'b1;
        win_d      = CH_W'(n);
        win_id_d   = sh_id_q[n];
        win_or_d   = sh_orient_q[n];
        win_flip_d = FLIP_MASK[n];
      end
    end
  end

  logic [ID_W-1:0] rom_id_q;
  logic [1:0]      rom_or_q;
  logic [LN_W-1:0] rom_line_q;
  logic [LN_W-1:0] s2_pxc_q;
  logic [CH_W-1:0] s2_win_q;
  logic            s2_flip_q;
  logic            s2_nohit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_id_q   <= '0;
      rom_or_q   <= 2'd0;
      rom_line_q <= '0;
      s2_pxc_q   <= '0;
      s2_win_q   <= NO_CH;
      s2_flip_q  <= 1'b0;
      s2_nohit_q <= 1'b1;
    end else begin
      rom_id_q   <= win_id_d;
      rom_or_q   <= win_or_d;
      rom_line_q <= s1_pxr_q;
      s2_pxc_q   <= s1_pxc_q;
      s2_win_q   <= win_d;
      s2_flip_q  <= win_flip_d;
      s2_nohit_q <= !found;
    end
  end

  assign rom_sprite_id = rom_id_q;
  assign rom_orient    = rom_or_q;
  assign rom_line      = rom_line_q;

  // ---- Stage 3: ROM row arrives, pick the (possibly mirrored) column ----
  logic            colour_d, colour_q;
  logic [CH_W-1:0] hit_q;

  assign colour_d = s2_nohit_q ? BG_COLOUR : rom_data[flip_col(s2_pxc_q, s2_flip_q)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colour_q <= BG_COLOUR;
      hit_q    <= NO_CH;
    end else begin
      colour_q <= colour_d;
      hit_q    <= s2_win_q;
    end
  end

  assign colour      = colour_q;
  assign hit_channel = hit_q;

`ifdef SPRITE_COLLISION_EN
  logic                    s2_multi_q;
  logic [NUM_ENTITIES-1:0] s2_hits_q;
  logic                    coll_q;
  logic [NUM_ENTITIES-1:0] cmask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_multi_q <= 1'b0;
      s2_hits_q  <= '0;
    end else begin
      s2_multi_q <= |(hits & (hits - NUM_ENTITIES'(1)));
      s2_hits_q  <= hits;
    end
  end

  // The frame-start clear wins over a set from the pixel leaving stage 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_q  <= 1'b0;
      cmask_q <= '0;
    end else if (snap) begin
      coll_q  <= 1'b0;
      cmask_q <= '0;
    end else if (s2_multi_q) begin
      coll_q  <= 1'b1;
      cmask_q <= cmask_q | s2_hits_q;
    end
  end

  assign collision      = coll_q;
  assign collision_mask = cmask_q;
`endif

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-channel tile frame-buffer path.
- Composites up to NUM_ENTITIES tile-aligned sprites onto the pixel stream, driven by the VGA H/V counters.
- Three-stage registered pipeline with entity snapshot per frame, fixed-priority overlap resolution, per-channel horizontal flip and an external synchronous sprite-ROM port.
- Sits between the game logic (entity words) and the VGA output driver.

Parameters:
NUM_ENTITIES, 9, number of entity channels
ID_W, 4, sprite ID width; all-ones ID = unused channel
LOC_W, 8, tile location width (linear index, row-major)
TILE_PX, 8, sprite pixels per tile edge
UPSCALE, 5, screen pixels per sprite pixel
SCREEN_TILES_H, 16, tiles per row
SCREEN_TILES_V, 12, tiles per column
FLIP_MASK, 9'b110000000, bit n set = channel n mirrored horizontally
BG_COLOUR, 1'b1, colour when no sprite is hit (1 = white)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
entities  in  NUM_ENTITIES*(ID_W+2+LOC_W)  packed; channel n at [n*EW +: EW], EW = ID_W+2+LOC_W; per-channel fields {ID, orientation[1:0], location}
counter_H  in  10  horizontal pixel counter
counter_V  in  10  vertical pixel counter
rom_sprite_id  out  ID_W  ROM sprite select
rom_orient  out  2  ROM orientation select
rom_line  out  log2(TILE_PX)  ROM row index
rom_data  in  TILE_PX  ROM row, valid exactly 1 cycle after the address
colour  out  1  composited pixel, 0 = black, 1 = white
hit_channel  out  log2(NUM_ENTITIES+1)  winning channel index; NUM_ENTITIES = none

Behaviour:
- Reset (reset = 0, async): all shadow IDs are set to all-ones, all pipeline registers are cleared, colour = BG_COLOUR, hit_channel = NUM_ENTITIES, ROM outputs = 0.
- Snapshot:
  - When counter_H == 0 and counter_V == 0, entities are latched into shadow registers on that edge.
  - All detection uses the shadow registers, so there is no mid-frame tearing.
  - Until the first snapshot after reset, output is background only.
- TILE_LEN = TILE_PX*UPSCALE (40).
- Stage 1 (S1, register):
  - tile_col = H/TILE_LEN, tile_row = V/TILE_LEN.
  - px_col = (H%TILE_LEN)/UPSCALE, px_row = (V%TILE_LEN)/UPSCALE.
  - Channel n hits when its ID != all-ones, its location == tile_row*SCREEN_TILES_H + tile_col, H < SCREEN_TILES_H*TILE_LEN and V < SCREEN_TILES_V*TILE_LEN.
  - Out-of-area pixels never hit; there is no aliasing of location values above 191.
- Stage 2 (S2, register):
  - The lowest-index hitting channel wins.
  - The ROM address {ID, orientation, px_row} of the winner is driven from registers.
  - px_col, the winner index and the flip bit are carried forward.
  - If no channel hits, ID all-ones is driven and a no-hit flag is carried.
- Stage 3 (S3, register):
  - Column index c = flip ? (TILE_PX-1-px_col) : px_col.
  - colour = no-hit ? BG_COLOUR : rom_data[c].
  - hit_channel is updated in the same cycle.
- Latency: exactly 3 clk from counter values to colour/hit_channel. Fully pipelined, one pixel per clock, no stalls.
- The snapshot takes effect for the pixel at (0,0) of the same frame; the S1 compare of that pixel uses the new values.
- Simultaneous hits are legal; only the priority winner is shown (no blending).
- Arithmetic uses constant divide/modulo only; intermediate widths are sized to hold the max counter value (1023) without truncation.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - Adds output collision (1 bit) and output collision_mask (NUM_ENTITIES bits).
  - Any visible pixel where 2 or more channels hit sets collision and ORs those channels into collision_mask.
  - Both are sticky and cleared on the snapshot edge.
  - Both are registered and aligned with S3.
  - Both reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sprite_pkg:
  - ENTITY_W, UNUSED_ID, TILE_LEN
  - entity field offsets
  - function tile_index(H, V)
  - function flip_col(col, flip)
- Sub-module sprite_hit_detector: one per channel via generate. Combinational compare of a shadow entity against S1 tile coordinates, producing a hit bit.

Test Plan:
- Reset released with entities loaded, frame not yet wrapped -> colour = 1 and hit_channel = 9 for all pixels until (0,0).
- Channel 0 = {ID 2, orient 0, loc 17}, ROM row = 8'b10110000, scan V = 45, H = 40..79 -> output 3 cycles later follows rom_data[(H-40)/5] per 5-pixel group; hit_channel = 0.
- Channels 3 and 5 both at loc 0 -> hit_channel = 3 and the ROM is addressed with channel 3's ID.
- Channel 8 (flipped) at loc 0, ROM row = 8'b00000001, H = 0..4 -> colour = rom_data[7] = 0; H = 35..39 -> rom_data[0] = 1.
- Entity loc changed mid-frame from 5 to 6 -> tile 5 keeps rendering until the next (0,0); tile 6 renders after it.
- SPRITE_COLLISION_EN: channels 1 and 2 at loc 20 -> collision = 1 and collision_mask = 9'b000000110 after the tile is scanned; both clear at the next snapshot.
